// File: rtl/ac97_sample_writer_if.sv
// ac97_sample_writer_if: CPU register bus plus the FIFO write port of the
// AC97 sample writer, bundled so the writer and its environment share one
// set of wires. The slave modport is the writer's view; the master modport
// is the side that drives the CPU strobes and the FIFO full flag.
interface ac97_sample_writer_if #(
  parameter int SAMPLE_WIDTH = 20
);
  logic [3:0]              addr;
  logic [31:0]             wdata;
  logic                    we;
  logic                    re;
  logic [31:0]             rdata;
  logic [SAMPLE_WIDTH-1:0] fifo_din;
  logic                    fifo_wr_en;
  logic                    fifo_full;

  modport slave (
    input  addr, wdata, we, re, fifo_full,
    output rdata, fifo_din, fifo_wr_en
  );

  modport master (
    output addr, wdata, we, re, fifo_full,
    input  rdata, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/ac97_sample_writer.sv
// ac97_sample_writer: memory-mapped stage in front of the AC97 sample async
// FIFO. CPU writes to TX_DATA are saturated to SAMPLE_WIDTH, attenuated by an
// arithmetic right shift of the volume amount, and queued in a 2-entry buffer
// that drains into the FIFO one sample per cycle whenever the FIFO is not
// full. STATUS, VOLUME and COUNT are readable for polling.
// Optional build macro AC97_VOL_ZC_EN: volume changes wait for a zero
// crossing of the captured samples instead of taking effect immediately.
module ac97_sample_writer #(
  parameter int SAMPLE_WIDTH = 20,
  parameter int VOL_WIDTH    = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  ac97_sample_writer_if.slave bus
);

  localparam logic [3:0] ADDR_TX     = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_VOLUME = 4'h8;
  localparam logic [3:0] ADDR_COUNT  = 4'hC;

  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SAMPLE_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (SAMPLE_WIDTH - 1));

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e state_q, state_d;

  logic [SAMPLE_WIDTH-1:0] buf0_q, buf0_d;
  logic [SAMPLE_WIDTH-1:0] buf1_q, buf1_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [VOL_WIDTH-1:0]    volReq_q, volReq_d;

  logic                    pop;
  logic                    ready;
  logic                    txWrite;
  logic                    txAccept;
  logic                    txDrop;
  logic                    volWrite;
  logic                    ovClear;
  logic                    countClear;
  logic                    writeSlot1;
  logic                    statusPending;
  logic [VOL_WIDTH-1:0]    volUse;
  logic signed [31:0]      wdataSigned;
  logic signed [SAMPLE_WIDTH-1:0] satSample;
  logic signed [SAMPLE_WIDTH-1:0] shiftedSample;
  logic [31:0]             readVal;

`ifdef AC97_VOL_ZC_EN
  logic [VOL_WIDTH-1:0]    volAct_q, volAct_d;
  logic                    volPending_q, volPending_d;
  logic                    prevNeg_q, prevNeg_d;
  logic                    zcHit;
  logic                    volSwap;
`endif

  assign wdataSigned = $signed(bus.wdata);
  assign txWrite     = bus.we && (bus.addr == ADDR_TX);
  assign volWrite    = bus.we && (bus.addr == ADDR_VOLUME);
  assign ovClear     = bus.we && (bus.addr == ADDR_STATUS) && bus.wdata[1];
  assign countClear  = bus.we && (bus.addr == ADDR_COUNT);
  assign txAccept    = txWrite && (ready || pop);
  assign txDrop      = txWrite && !txAccept;

  // Clamp the signed CPU word into the signed sample range.
  always_comb begin
    satSample = wdataSigned[SAMPLE_WIDTH-1:0];
    if (wdataSigned > SAT_MAX) begin
      satSample = SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (wdataSigned < SAT_MIN) begin
      satSample = SAT_MIN[SAMPLE_WIDTH-1:0];
    end
  end

`ifdef AC97_VOL_ZC_EN
  // Swap to the requested volume only on a zero or sign-change sample.
  always_comb begin
    zcHit   = (satSample == '0) || (satSample[SAMPLE_WIDTH-1] != prevNeg_q);
    volSwap = txAccept && volPending_q && zcHit;
    volUse  = volSwap ? volReq_q : volAct_q;
  end
  assign statusPending = volPending_q;
`else
  assign volUse        = volReq_q;
  assign statusPending = 1'b0;
`endif

  assign shiftedSample = satSample >>> volUse;

  // State register: buffer occupancy.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy from the accept and pop events of this cycle.
  always_comb begin
    state_d = state_q;
    case ({txAccept, pop})
      2'b10: begin
        case (state_q)
          OCC_EMPTY: state_d = OCC_ONE;
          OCC_ONE:   state_d = OCC_TWO;
          default:   state_d = state_q;
        endcase
      end
      2'b01: begin
        case (state_q)
          OCC_TWO: state_d = OCC_ONE;
          OCC_ONE: state_d = OCC_EMPTY;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs decoded from occupancy; pushes are held off while in reset.
  always_comb begin
    ready          = (state_q != OCC_TWO);
    pop            = rst_b && (state_q != OCC_EMPTY) && !bus.fifo_full;
    bus.fifo_wr_en = pop;
    bus.fifo_din   = buf0_q;
    bus.rdata      = rdata_q;
  end

  // Register read multiplexer; unmapped offsets read as zero.
  always_comb begin
    readVal = '0;
    case (bus.addr)
      ADDR_STATUS: readVal = {27'd0, state_q, statusPending, overflow_q, ready};
      ADDR_VOLUME: readVal = {{(32 - VOL_WIDTH){1'b0}}, volReq_q};
      ADDR_COUNT:  readVal = count_q;
      default:     readVal = '0;
    endcase
  end

  // Next values for the buffer slots and the CPU-visible registers.
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    writeSlot1 = (state_q == OCC_TWO) || ((state_q == OCC_ONE) && !pop);
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (txAccept) begin
      if (writeSlot1) begin
        buf1_d = shiftedSample;
      end else begin
        buf0_d = shiftedSample;
      end
    end
    overflow_d = txDrop || (overflow_q && !ovClear);
    volReq_d   = volWrite ? bus.wdata[VOL_WIDTH-1:0] : volReq_q;
    count_d    = count_q;
    if (pop) begin
      count_d = count_q + 32'd1;
    end
    if (countClear) begin
      count_d = '0;
    end
    rdata_d = bus.re ? readVal : rdata_q;
  end

`ifdef AC97_VOL_ZC_EN
  // Zero-crossing bookkeeping: pending flag, active volume, last sign.
  always_comb begin
    volPending_d = volPending_q;
    if (volSwap) begin
      volPending_d = 1'b0;
    end
    if (volWrite) begin
      volPending_d = 1'b1;
    end
    volAct_d  = volSwap ? volReq_q : volAct_q;
    prevNeg_d = txAccept ? satSample[SAMPLE_WIDTH-1] : prevNeg_q;
  end

  // Zero-crossing registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      volAct_q     <= '0;
      volPending_q <= 1'b0;
      prevNeg_q    <= 1'b0;
    end else begin
      volAct_q     <= volAct_d;
      volPending_q <= volPending_d;
      prevNeg_q    <= prevNeg_d;
    end
  end
`endif

  // Datapath and register file; reset discards any buffered samples.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      rdata_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      volReq_q   <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      rdata_q    <= rdata_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      volReq_q   <= volReq_d;
    end
  end

endmodule

// File: tb/tb_ac97_sample_writer.sv
// tb_ac97_sample_writer: directed bench for ac97_sample_writer. Expected FIFO
// pushes are produced by a small saturate/attenuate model and queued when a
// sample is written; a negedge monitor pops and compares them as pushes occur.
// Build with AC97_VOL_ZC_EN defined to also exercise zero-crossing volume.
module tb_ac97_sample_writer;

  localparam int SW = 20;

  typedef struct {
    logic [SW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   cyc        = 0;

  int   mVolReq  = 0;
  int   mVolAct  = 0;
  bit   mPending = 1'b0;
  bit   mPrevNeg = 1'b0;

  ac97_sample_writer_if #(.SAMPLE_WIDTH(SW)) bus ();

  ac97_sample_writer #(
    .SAMPLE_WIDTH(SW),
    .VOL_WIDTH   (4)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check push latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference model: clamp, optional zero-crossing swap, floor divide.
  function automatic logic [SW-1:0] modelSample(input int val);
    int sat;
    int d;
    int q;
    sat = val;
    if (sat > 524287) sat = 524287;
    else if (sat < -524288) sat = -524288;
`ifdef AC97_VOL_ZC_EN
    if (mPending && ((sat == 0) || ((sat < 0) != mPrevNeg))) begin
      mVolAct  = mVolReq;
      mPending = 1'b0;
    end
    mPrevNeg = (sat < 0);
`else
    mVolAct = mVolReq;
`endif
    d = 1 << mVolAct;
    q = sat / d;
    if ((sat < 0) && (q * d != sat)) q = q - 1;
    return q[SW-1:0];
  endfunction

  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
  endtask

  task automatic writeSample(input int val, input bit accepted, input bit timed);
    exp_t e;
    if (accepted) begin
      e.data = modelSample(val);
      e.due  = timed ? cyc + 1 : -1;
      expQ.push_back(e);
    end
    applyStimulus(4'h0, val);
  endtask

  task automatic writeVolume(input int v);
    mVolReq = v;
`ifdef AC97_VOL_ZC_EN
    mPending = 1'b1;
`endif
    applyStimulus(4'h8, v);
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk);
    #1;
    bus.re   = 1'b0;
    d        = bus.rdata;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] expv);
    logic [31:0] d;
    readReg(a, d);
    checkOutput(tag, d, expv);
  endtask

  // Scoreboard monitor: every push must match the oldest expected sample.
  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousPush", 32'(expQ.size()), 32'd1);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("pushData", {12'd0, bus.fifo_din}, {12'd0, e.data});
        if (e.due >= 0) checkOutput("pushLatency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_b         = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Reset state.
    checkOutput("rstRdata", bus.rdata, 32'd0);
    checkOutput("rstWrEn", 32'(bus.fifo_wr_en), 32'd0);
    readCheck("rstStatus", 4'h4, 32'h1);
    readCheck("undefRead", 4'h2, 32'h0);
    readCheck("rstVolume", 4'h8, 32'h0);
    readCheck("rstCount", 4'hC, 32'h0);

    // Test 1: -50..50 back to back, one push per cycle, one cycle latency.
    for (int v = -50; v <= 50; v++) writeSample(v, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    readCheck("count101", 4'hC, 32'd101);
    bus.addr  = 4'hC;
    bus.wdata = 32'd0;
    bus.we    = 1'b1;
    bus.re    = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    checkOutput("readBeforeWrite", bus.rdata, 32'd101);
    readCheck("countCleared", 4'hC, 32'd0);

    // Test 2: FIFO full, third write overflows.
    bus.fifo_full = 1'b1;
    writeSample(1, 1'b1, 1'b0);
    writeSample(2, 1'b1, 1'b0);
    writeSample(3, 1'b0, 1'b0);
    readCheck("statusFull", 4'h4, 32'h12);
    bus.fifo_full = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("drained", 32'(expQ.size()), 32'd0);
    applyStimulus(4'h4, 32'h2);
    readCheck("overflowCleared", 4'h4, 32'h1);

    // Test 3: saturation boundaries.
    writeSample(32'h7FFFFFFF, 1'b1, 1'b1);
    writeSample(32'h80000000, 1'b1, 1'b1);
    writeSample(32'h0007FFFF, 1'b1, 1'b1);
    writeSample(-524288, 1'b1, 1'b1);

    // Test 4: attenuation by 2 with floor toward minus infinity.
    writeVolume(2);
    readCheck("volume2", 4'h8, 32'd2);
    writeSample(-5, 1'b1, 1'b1);
    writeSample(5, 1'b1, 1'b1);
    writeSample(-1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Test 5: reset while buffer is full and FIFO full.
    bus.fifo_full = 1'b1;
    writeSample(7, 1'b0, 1'b0);
    writeSample(8, 1'b0, 1'b0);
    writeSample(9, 1'b0, 1'b0);
    bus.fifo_full = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checkOutput("wrEnInReset", 32'(bus.fifo_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_b    = 1'b1;
    mVolReq  = 0;
    mVolAct  = 0;
    mPending = 1'b0;
    mPrevNeg = 1'b0;
    checkOutput("resetRdata", bus.rdata, 32'd0);
    readCheck("resetStatus", 4'h4, 32'h1);
    readCheck("resetCount", 4'hC, 32'h0);
    readCheck("resetVolume", 4'h8, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("noStalePush", 32'(expQ.size()), 32'd0);

`ifdef AC97_VOL_ZC_EN
    // Test 6: volume change deferred to the next zero crossing.
    writeSample(100, 1'b1, 1'b1);
    writeVolume(1);
    readCheck("pendingSet", 4'h4, 32'h5);
    writeSample(100, 1'b1, 1'b1);
    writeSample(80, 1'b1, 1'b1);
    readCheck("pendingHeld", 4'h4, 32'h5);
    writeSample(-40, 1'b1, 1'b1);
    readCheck("pendingCleared", 4'h4, 32'h1);
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
